pulse_window_capture: RTL and testbench

//  Parametrised trigger-gated waveform window and pulse-height extractor for the ADC stream.
//  On a trigger it forwards a fixed-length window of ADC samples for the UART waveform path.
//  It then reports peak-minus-pedestal, the peak sample index and a pile-up flag.

---
 rtl/pulse_window_capture.sv | 140 ++++++++++++++
 tb/tb_pulse_window_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_window_capture.sv
// Trigger-gated ADC window forwarder with peak-minus-pedestal pulse height extraction.
// Optional macro PULSE_PED_AVG_EN selects an IIR pedestal instead of last-idle-sample pedestal.
module pulse_window_capture #(
  parameter int DATA_W   = 14,
  parameter int WIN_LEN  = 42,
  parameter int HOLDOFF  = 0,
  parameter int PED_LOG2 = 3,
  localparam int CNT_W   = $clog2(WIN_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger_in,
  input  logic              polarity,
  input  logic [DATA_W-1:0] signal,
  output logic [DATA_W-1:0] result,
  output logic              window_active,
  output logic [CNT_W-1:0]  sample_idx,
  output logic [DATA_W-1:0] pulse_height,
  output logic [CNT_W-1:0]  peak_idx,
  output logic              pileup,
  output logic              height_valid
);

  localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] ped;
  logic [DATA_W-1:0] ped_next;
  logic [DATA_W-1:0] peak;
  logic [DATA_W-1:0] height_calc;
  logic [HO_W-1:0]   holdoff_cnt;
  logic              pol;
  logic              pileup_acc;
  logic              better;
  logic              last_sample;

`ifdef PULSE_PED_AVG_EN
  logic                ped_init;
  logic signed [DATA_W:0] ped_diff;
  logic signed [DATA_W:0] ped_avg;

  always_comb begin
    ped_diff = $signed({1'b0, signal}) - $signed({1'b0, ped});
    ped_avg  = $signed({1'b0, ped}) + (ped_diff >>> PED_LOG2);
    ped_next = ped_init ? ped_avg[DATA_W-1:0] : signal;
  end

  always_ff @(posedge clk) begin
    if (rst) ped_init <= 1'b0;
    else if (state == S_IDLE && !trigger_in) ped_init <= 1'b1;
  end
`else
  assign ped_next = signal;
`endif

  always_comb begin
    better      = pol ? (signal < peak) : (signal > peak);
    last_sample = (sample_idx == CNT_W'(WIN_LEN - 1));
    height_calc = '0;
    // Difference is clamped at zero so a pulse below pedestal reads as no pulse.
    if (pol) begin
      if (ped > peak) height_calc = ped - peak;
    end else begin
      if (peak > ped) height_calc = peak - ped;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      result        <= '0;
      window_active <= 1'b0;
      sample_idx    <= '0;
      pulse_height  <= '0;
      peak_idx      <= '0;
      pileup        <= 1'b0;
      height_valid  <= 1'b0;
      ped           <= '0;
      peak          <= '0;
      holdoff_cnt   <= '0;
      pol           <= 1'b0;
      pileup_acc    <= 1'b0;
    end else begin
      height_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          sample_idx <= '0;
          if (trigger_in) begin
            state         <= S_CAPTURE;
            result        <= signal;
            window_active <= 1'b1;
            pol           <= polarity;
            peak          <= signal;
            peak_idx      <= '0;
            pileup_acc    <= 1'b0;
          end else begin
            result        <= '0;
            window_active <= 1'b0;
            ped           <= ped_next;
          end
        end
        S_CAPTURE: begin
          if (!last_sample) begin
            sample_idx <= sample_idx + CNT_W'(1);
            result     <= signal;
            pileup_acc <= pileup_acc | trigger_in;
            if (better) begin
              peak     <= signal;
              peak_idx <= sample_idx + CNT_W'(1);
            end
          end else begin
            result        <= '0;
            window_active <= 1'b0;
            sample_idx    <= '0;
            height_valid  <= 1'b1;
            pulse_height  <= height_calc;
            pileup        <= pileup_acc | trigger_in;
            if (HOLDOFF > 0) begin
              state       <= S_HOLDOFF;
              holdoff_cnt <= HO_W'(HOLDOFF);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HOLDOFF: begin
          result      <= '0;
          holdoff_cnt <= holdoff_cnt - HO_W'(1);
          if (holdoff_cnt <= HO_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_window_capture.sv
// Directed self-checking bench for pulse_window_capture (DATA_W=14, WIN_LEN=8, HOLDOFF=2, PED_LOG2=2).
module tb_pulse_window_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger_in;
  logic        polarity;
  logic [13:0] signal;
  logic [13:0] result;
  logic        window_active;
  logic [2:0]  sample_idx;
  logic [13:0] pulse_height;
  logic [2:0]  peak_idx;
  logic        pileup;
  logic        height_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pulse_window_capture #(
    .DATA_W(14),
    .WIN_LEN(8),
    .HOLDOFF(2),
    .PED_LOG2(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trigger_in(trigger_in),
    .polarity(polarity),
    .signal(signal),
    .result(result),
    .window_active(window_active),
    .sample_idx(sample_idx),
    .pulse_height(pulse_height),
    .peak_idx(peak_idx),
    .pileup(pileup),
    .height_valid(height_valid)
  );

  typedef struct {
    logic        trig;
    logic [13:0] sig;
    logic [13:0] exp_res;
    logic        exp_act;
    logic [2:0]  exp_idx;
    logic        exp_hv;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic t, input logic p, input logic [13:0] s);
    @(negedge clk);
    trigger_in = t;
    polarity   = p;
    signal     = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [13:0] s);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, s);
      chk("idle_hv", height_valid, 0);
      chk("idle_result", result, 0);
    end
  endtask

  // Baseline of 3 edges, trigger edge, 7 capture edges, closing edge with height_valid.
  task automatic window(input logic p, input logic [13:0] base, input logic [13:0] w[8],
                        input logic [7:0] trigmask);
    for (int i = 0; i < 3; i++) step(1'b0, p, base);
    for (int i = 0; i < 8; i++) begin
      step((i == 0) ? 1'b1 : trigmask[i], (i == 0) ? p : ~p, w[i]);
      chk("win_result", result, w[i]);
      chk("win_active", window_active, 1);
      chk("win_idx", sample_idx, i);
      chk("win_hv", height_valid, 0);
    end
    step(1'b0, p, base);
    chk("final_hv", height_valid, 1);
    chk("final_active", window_active, 0);
    chk("final_result", result, 0);
    chk("final_idx", sample_idx, 0);
  endtask

  logic [13:0] w[8];
  logic [13:0] exp_ped_h;

  initial begin
    rst = 1'b1; trigger_in = 1'b0; polarity = 1'b0; signal = '0;
    vt[0]  = '{1'b0, 14'd100, 14'd0,   1'b0, 3'd0, 1'b0};
    vt[1]  = '{1'b0, 14'd100, 14'd0,   1'b0, 3'd0, 1'b0};
    vt[2]  = '{1'b0, 14'd100, 14'd0,   1'b0, 3'd0, 1'b0};
    vt[3]  = '{1'b1, 14'd100, 14'd100, 1'b1, 3'd0, 1'b0};
    vt[4]  = '{1'b0, 14'd150, 14'd150, 1'b1, 3'd1, 1'b0};
    vt[5]  = '{1'b0, 14'd300, 14'd300, 1'b1, 3'd2, 1'b0};
    vt[6]  = '{1'b0, 14'd250, 14'd250, 1'b1, 3'd3, 1'b0};
    vt[7]  = '{1'b0, 14'd200, 14'd200, 1'b1, 3'd4, 1'b0};
    vt[8]  = '{1'b0, 14'd150, 14'd150, 1'b1, 3'd5, 1'b0};
    vt[9]  = '{1'b0, 14'd120, 14'd120, 1'b1, 3'd6, 1'b0};
    vt[10] = '{1'b0, 14'd100, 14'd100, 1'b1, 3'd7, 1'b0};
    vt[11] = '{1'b0, 14'd100, 14'd0,   1'b0, 3'd0, 1'b1};
    vt[12] = '{1'b0, 14'd100, 14'd0,   1'b0, 3'd0, 1'b0};
    vt[13] = '{1'b0, 14'd100, 14'd0,   1'b0, 3'd0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_active", window_active, 0);
    chk("rst_idx", sample_idx, 0);
    chk("rst_height", pulse_height, 0);
    chk("rst_peak_idx", peak_idx, 0);
    chk("rst_pileup", pileup, 0);
    chk("rst_hv", height_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: positive pulse, table-driven
    for (int i = 0; i < 14; i++) begin
      step(vt[i].trig, 1'b0, vt[i].sig);
      chk("t1_result", result, vt[i].exp_res);
      chk("t1_active", window_active, vt[i].exp_act);
      chk("t1_idx", sample_idx, vt[i].exp_idx);
      chk("t1_hv", height_valid, vt[i].exp_hv);
    end
    chk("t1_height", pulse_height, 200);
    chk("t1_peak_idx", peak_idx, 2);
    chk("t1_pileup", pileup, 0);

    // Test 2: negative pulse, polarity latched at trigger only
    w = '{14'd1000, 14'd900, 14'd800, 14'd700, 14'd600, 14'd400, 14'd500, 14'd700};
    window(1'b1, 14'd1000, w, 8'h00);
    chk("t2_height", pulse_height, 600);
    chk("t2_peak_idx", peak_idx, 5);
    chk("t2_pileup", pileup, 0);
    idle(2, 14'd1000);

    // Test 3: window below pedestal saturates to zero, ties keep index 0
    w = '{14'd300, 14'd300, 14'd300, 14'd300, 14'd300, 14'd300, 14'd300, 14'd300};
    window(1'b0, 14'd500, w, 8'h00);
    chk("t3_height", pulse_height, 0);
    chk("t3_peak_idx", peak_idx, 0);
    idle(2, 14'd500);

    // Test 4: retrigger inside window, during holdoff, and on first idle edge
    w = '{14'd100, 14'd120, 14'd180, 14'd260, 14'd220, 14'd160, 14'd130, 14'd110};
    window(1'b0, 14'd100, w, 8'b0000_1000);
    chk("t4_pileup", pileup, 1);
    chk("t4_height", pulse_height, 160);
    chk("t4_peak_idx", peak_idx, 3);
    step(1'b1, 1'b0, 14'd900);
    chk("t4_ho_active", window_active, 0);
    chk("t4_ho_result", result, 0);
    chk("t4_ho_hv", height_valid, 0);
    step(1'b0, 1'b0, 14'd100);
    chk("t4_ho2_active", window_active, 0);
    step(1'b1, 1'b0, 14'd77);
    chk("t4_new_active", window_active, 1);
    chk("t4_new_result", result, 77);
    chk("t4_new_idx", sample_idx, 0);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 14'd77);
      chk("t4_new_idx", sample_idx, i);
    end
    step(1'b0, 1'b0, 14'd77);
    chk("t4_new_hv", height_valid, 1);
    chk("t4_new_pileup", pileup, 0);
    idle(2, 14'd77);

    // Test 5: reset in the middle of a window
    step(1'b0, 1'b0, 14'd200);
    step(1'b1, 1'b0, 14'd200);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 14'd500);
    @(negedge clk);
    rst = 1'b1; trigger_in = 1'b0; signal = 14'd500;
    @(posedge clk);
    #1;
    chk("t5_result", result, 0);
    chk("t5_active", window_active, 0);
    chk("t5_idx", sample_idx, 0);
    chk("t5_height", pulse_height, 0);
    chk("t5_peak_idx", peak_idx, 0);
    chk("t5_pileup", pileup, 0);
    chk("t5_hv", height_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(10, 14'd500);
    w = '{14'd100, 14'd200, 14'd350, 14'd300, 14'd250, 14'd200, 14'd150, 14'd100};
    window(1'b0, 14'd100, w, 8'h00);
    chk("t5_new_height", pulse_height, 250);
    chk("t5_new_peak_idx", peak_idx, 2);
    idle(2, 14'd100);

    // Test 6: pedestal step response (averaged or last-sample)
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    idle(2, 14'd0);
    w = '{14'd400, 14'd400, 14'd400, 14'd400, 14'd400, 14'd400, 14'd400, 14'd400};
`ifdef PULSE_PED_AVG_EN
    exp_ped_h = 14'd169;
`else
    exp_ped_h = 14'd0;
`endif
    window(1'b0, 14'd400, w, 8'h00);
    chk("t6_height", pulse_height, exp_ped_h);
    chk("t6_peak_idx", peak_idx, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
